// File: rtl/cpu_qsys_jtag_pkg.sv
// cpu_qsys_jtag_pkg: shared constants and channel encoding for the JTAG command queue
package cpu_qsys_jtag_pkg;
  localparam int JTAG_ACT_BIT_DFLT = 34;
  typedef enum logic [1:0] {
    CH_OCIMEM    = 2'd0,
    CH_TRACEMEM  = 2'd1,
    CH_BREAK     = 2'd2,
    CH_TRACECTRL = 2'd3
  } jtag_ch_e;
endpackage

// File: rtl/cpu_qsys_jtag_strobe_sync.sv
// cpu_qsys_jtag_strobe_sync: synchronise an async strobe and emit one pulse per rising edge (clk, reset, async_in -> evt)
module cpu_qsys_jtag_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic evt
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic [CW-1:0] cnt;
  logic settled;
  assign settled = cnt == CW'(SYNC_STAGES + 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      hist <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      hist <= sync[SYNC_STAGES-1];
      cnt  <= settled ? cnt : cnt + 1'b1;
    end
  end
  // history resets low, so a level already high at release is masked until the chain has filled
  assign evt = sync[SYNC_STAGES-1] & ~hist & settled;
endmodule

// File: rtl/cpu_qsys_jtag_cmd_queue.sv
// cpu_qsys_jtag_cmd_queue: capture JTAG update strobes into a FIFO and hand commands to OCI via valid/ready (clk, reset, sr, ir_in, vs_udr, vs_uir, cmd_ready, ovf_clr -> cmd_valid, jdo, cmd_ir, take_action, take_no_action, ir_update, overflow, level)
module cpu_qsys_jtag_cmd_queue
  import cpu_qsys_jtag_pkg::*;
#(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = JTAG_ACT_BIT_DFLT,
  localparam int N_CMD      = 2 ** IR_W,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic              cmd_ready,
  input  logic              ovf_clr,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] jdo,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [N_CMD-1:0]  take_action,
  output logic [N_CMD-1:0]  take_no_action,
  output logic              ir_update,
  output logic              overflow,
  output logic [AW:0]       level
);
  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;
  cmd_t mem [DEPTH];
  cmd_t head;
  logic [AW:0] wptr, rptr;
  logic udr_evt, uir_evt, full, pop, push, drop;
  cpu_qsys_jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .async_in(vs_udr), .evt(udr_evt)
  );
  cpu_qsys_jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .async_in(vs_uir), .evt(uir_evt)
  );
  assign head      = mem[rptr[AW-1:0]];
  assign cmd_valid = wptr != rptr;
  assign full      = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign pop       = cmd_valid & cmd_ready;
  // a pop frees the slot in the same cycle, so a push onto a full queue is kept
  assign push      = udr_evt & (~full | pop);
  assign drop      = udr_evt & full & ~pop;
  assign jdo       = cmd_valid ? head.data : '0;
  assign cmd_ir    = cmd_valid ? head.ir : '0;
  assign level     = wptr - rptr;
  assign ir_update = uir_evt;
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{ir: ir_in, data: sr};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr           <= '0;
      rptr           <= '0;
      overflow       <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      wptr           <= wptr + {{AW{1'b0}}, push};
      rptr           <= rptr + {{AW{1'b0}}, pop};
      overflow       <= drop | (overflow & ~ovf_clr);
      take_action    <= (pop && jdo[ACT_BIT]) ? N_CMD'(1) << cmd_ir : '0;
      take_no_action <= (pop && !jdo[ACT_BIT]) ? N_CMD'(1) << cmd_ir : '0;
    end
  end
endmodule
